// File: rtl/eth_voice_pkg.sv
// rtl/eth_voice_pkg.sv - shared voice-link packet sizing, write FSM states and counter helper
package eth_voice_pkg;

  localparam int PDU_SIZE    = 1468;
  localparam int SLOT_WIDTH  = 2;
  localparam int OFF_WIDTH   = 11;
  localparam int IDENT_WIDTH = 8;
  localparam int IDX_WIDTH   = 8;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_STORE   = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/altdualram.sv
// rtl/altdualram.sv - simple dual-port RAM, one write port, one registered read port
module altdualram #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_receiver.sv
// rtl/eth_receiver.sv - voice-link receive packet buffer: slotted RAM, sequence tracking, in-order byte read-out
module eth_receiver
  import eth_voice_pkg::*;
#(
  parameter int SLOT_WIDTH = eth_voice_pkg::SLOT_WIDTH,
  parameter int OFF_WIDTH  = eth_voice_pkg::OFF_WIDTH,
  parameter int PDU_SIZE   = eth_voice_pkg::PDU_SIZE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic        i_rx_sof,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_eof,
  input  logic        i_rx_err,
  input  logic [7:0]  i_pck_ident,
  input  logic [7:0]  i_pck_idx,
  input  logic        i_rd,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_empty,
  output logic        o_full,
  output logic [7:0]  o_pck_ident,
  output logic [7:0]  o_pck_idx,
  output logic [15:0] o_lost_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam int NSLOTS = 1 << SLOT_WIDTH;
  localparam logic [OFF_WIDTH-1:0] PDU_MAX = OFF_WIDTH'(PDU_SIZE);

  wr_state_e             state;
  logic [SLOT_WIDTH:0]   wr_idx, rd_idx;
  logic [OFF_WIDTH-1:0]  wr_off, rd_off;
  logic [OFF_WIDTH-1:0]  len_q [NSLOTS];
  logic [15:0]           id_q  [NSLOTS];
  logic [7:0]            cur_ident, cur_idx, last_ident, last_idx;
  logic                  have_last;
  logic                  rd_fire, rd_fire_q;
  logic [7:0]            ram_q;

  logic [SLOT_WIDTH-1:0] wr_slot, rd_slot;
  assign wr_slot = wr_idx[SLOT_WIDTH-1:0];
  assign rd_slot = rd_idx[SLOT_WIDTH-1:0];

  assign o_empty     = (wr_idx == rd_idx);
  assign o_full      = (wr_idx[SLOT_WIDTH] != rd_idx[SLOT_WIDTH]) && (wr_slot == rd_slot);
  assign o_pck_ident = id_q[rd_slot][15:8];
  assign o_pck_idx   = id_q[rd_slot][7:0];

  // The sof byte always lands at offset 0 of the free slot, whatever state the FSM is in.
  logic                  ram_we;
  logic [OFF_WIDTH-1:0]  ram_woff;
  assign ram_we   = i_rx_valid && (i_rx_sof ? !o_full : (state == WR_STORE && wr_off != PDU_MAX));
  assign ram_woff = i_rx_sof ? {OFF_WIDTH{1'b0}} : wr_off;

  logic [7:0]  seq_d;
  logic        same_stream, late, gap;
  logic [16:0] lost_sum;
  assign seq_d       = cur_idx - last_idx;
  assign same_stream = have_last && (cur_ident == last_ident);
  assign late        = same_stream && (seq_d == 8'd0 || seq_d > 8'd128);
  assign gap         = same_stream && (seq_d >= 8'd2) && (seq_d <= 8'd128);
  assign lost_sum    = {1'b0, o_lost_cnt} + {9'd0, seq_d} - 17'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= WR_IDLE;
      wr_idx     <= '0;
      wr_off     <= '0;
      cur_ident  <= '0;
      cur_idx    <= '0;
      last_ident <= '0;
      last_idx   <= '0;
      have_last  <= 1'b0;
      o_lost_cnt <= '0;
      o_drop_cnt <= '0;
      for (int i = 0; i < NSLOTS; i++) begin
        len_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else if (i_rx_valid && i_rx_sof) begin
      if (state == WR_STORE) o_drop_cnt <= sat_inc(o_drop_cnt);
      if (o_full) begin
        state <= WR_DISCARD;
      end else begin
        state     <= WR_STORE;
        cur_ident <= i_pck_ident;
        cur_idx   <= i_pck_idx;
        wr_off    <= OFF_WIDTH'(1);
      end
    end else if (i_rx_valid && state == WR_STORE) begin
      if (wr_off == PDU_MAX) state <= WR_DISCARD;
      else                   wr_off <= wr_off + OFF_WIDTH'(1);
    end else if (i_rx_eof) begin
      case (state)
        WR_STORE: begin
          if (!i_rx_err && wr_off != '0 && !late) begin
            len_q[wr_slot] <= wr_off;
            id_q[wr_slot]  <= {cur_ident, cur_idx};
            wr_idx         <= wr_idx + 1'b1;
            last_ident     <= cur_ident;
            last_idx       <= cur_idx;
            have_last      <= 1'b1;
            if (gap) o_lost_cnt <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
          end else begin
            o_drop_cnt <= sat_inc(o_drop_cnt);
          end
          state <= WR_IDLE;
        end
        WR_DISCARD: begin
          o_drop_cnt <= sat_inc(o_drop_cnt);
          state      <= WR_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign rd_fire = i_rd && !o_empty;

  // Two-stage read: RAM register, then output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_idx    <= '0;
      rd_off    <= '0;
      rd_fire_q <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
    end else begin
      if (rd_fire) begin
        if (rd_off == len_q[rd_slot] - OFF_WIDTH'(1)) begin
          rd_off <= '0;
          rd_idx <= rd_idx + 1'b1;
        end else begin
          rd_off <= rd_off + OFF_WIDTH'(1);
        end
      end
      rd_fire_q <= rd_fire;
      o_valid   <= rd_fire_q;
      if (rd_fire_q) o_data <= ram_q;
    end
  end

  altdualram #(
    .ADDR_WIDTH(SLOT_WIDTH + OFF_WIDTH),
    .DATA_WIDTH(8)
  ) u_ram (
    .i_clk   (i_clk),
    .wr_en   (ram_we),
    .wr_addr ({wr_slot, ram_woff}),
    .wr_data (i_rx_data),
    .rd_en   (rd_fire),
    .rd_addr ({rd_slot, rd_off}),
    .rd_data (ram_q)
  );

endmodule
